// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control codes decoded by the ALU and the
// multiply sequencer, plus the sequencer state encoding.
package cpu_pkg;

  localparam logic [3:0] AND_CODE = 4'b0000;
  localparam logic [3:0] OR_CODE  = 4'b0001;
  localparam logic [3:0] ADD_CODE = 4'b0010;
  localparam logic [3:0] MUL_CODE = 4'b0011;
  localparam logic [3:0] SUB_CODE = 4'b0110;
  localparam logic [3:0] SLT_CODE = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-add multiply iteration, purely combinational.
module mul_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0] mplier_o
);

  // Sum wraps mod 2^WIDTH; only the low product bits are ever needed.
  assign acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
  assign mcand_o  = mcand_i << 1;
  assign mplier_o = mplier_i >> 1;

endmodule

// File: rtl/alu_mul_seq.sv
// EX-stage multi-cycle multiply sequencer (IDLE/RUN/DONE) that stalls the
// front of the pipe while busy. ALU_MUL_SEQ_EARLY_TERM_EN enables early exit.
module alu_mul_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] result_o,
  output logic             result_valid_o
);

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, result_q;
  logic [WIDTH-1:0] mcand_nxt, mplier_nxt, acc_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             start;
  logic             last_step;

  assign start = valid_i & (ALUCtrl_i == MUL_CODE) & ~flush_i;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_nxt),
    .mcand_o  (mcand_nxt),
    .mplier_o (mplier_nxt)
  );

`ifdef ALU_MUL_SEQ_EARLY_TERM_EN
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1)) | (mplier_nxt == '0);
`else
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  // NOTE: every output of this block is given a default before the case so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          stall_o = 1'b1;
`ifdef ALU_MUL_SEQ_EARLY_TERM_EN
          state_d = (src2_i == '0) ? DONE : RUN;
`else
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        // A squashed instruction releases the pipe in the same cycle.
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          stall_o = 1'b1;
          if (last_step) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= src1_i;
            mplier_q <= src2_i;
            acc_q    <= '0;
            cnt_q    <= '0;
`ifdef ALU_MUL_SEQ_EARLY_TERM_EN
            if (src2_i == '0) result_q <= '0;
`endif
          end
        end
        RUN: begin
          if (!flush_i) begin
            acc_q    <= acc_nxt;
            mcand_q  <= mcand_nxt;
            mplier_q <= mplier_nxt;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (last_step) result_q <= acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o         = (state_q == RUN);
  assign result_valid_o = (state_q == DONE);
  assign result_o       = result_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: table-driven multiplies plus directed
// flush, reset, passthrough and back-to-back sequences.
module tb_alu_mul_seq;
  import cpu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic [3:0]       ALUCtrl_i;
  logic [WIDTH-1:0] src1_i, src2_i;
  logic             flush_i;
  logic             stall_o, busy_o, result_valid_o;
  logic [WIDTH-1:0] result_o;

  int checks = 0;
  int errors = 0;

  alu_mul_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .ALUCtrl_i      (ALUCtrl_i),
    .src1_i         (src1_i),
    .src2_i         (src2_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .busy_o         (busy_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected accept-to-result_valid latency for a given multiplier.
  function automatic int exp_lat(input logic [31:0] b);
`ifdef ALU_MUL_SEQ_EARLY_TERM_EN
    if (b == 0) return 1;
    for (int i = 31; i >= 0; i--) if (b[i]) return i + 2;
    return 1;
`else
    return WIDTH + 1;
`endif
  endfunction

  // Presents a mul at the next cycle T and watches until result_valid_o.
  // Leaves the inputs driven so a following call issues back-to-back.
  task automatic do_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] prod);
    int stall_cnt = 0;
    int vcycle    = -1;
    logic [31:0] got = '0;
    @(posedge clk_i); #1;
    valid_i   = 1'b1;
    ALUCtrl_i = MUL_CODE;
    src1_i    = a;
    src2_i    = b;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk_i);
      if (stall_o) stall_cnt++;
      if (result_valid_o) begin
        vcycle = k;
        got    = result_o;
        break;
      end
    end
    check({name, " latency"}, 32'(vcycle), 32'(exp_lat(b)));
    check({name, " stall cycles"}, 32'(stall_cnt), 32'(exp_lat(b)));
    check({name, " product"}, got, prod);
  endtask

  task automatic release_bus();
    @(posedge clk_i); #1;
    valid_i   = 1'b0;
    ALUCtrl_i = ADD_CODE;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"7x6",          32'd7,          32'd6,          32'd42};
    vecs[1] = '{"ffff_sq",      32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
    vecs[2] = '{"msb_x2",       32'h8000_0000,  32'd2,          32'h0000_0000};
    vecs[3] = '{"x3",           32'h1234_5678,  32'd3,          32'h369D_0368};
    vecs[4] = '{"b_zero",       32'd5,          32'd0,          32'd0};
    vecs[5] = '{"ffff_x10001",  32'h0000_FFFF,  32'h0001_0001,  32'hFFFF_FFFF};
    vecs[6] = '{"5x1",          32'd5,          32'd1,          32'd5};

    rst_i = 1'b1; valid_i = 1'b0; ALUCtrl_i = ADD_CODE;
    src1_i = '0; src2_i = '0; flush_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset outputs", {28'd0, stall_o, busy_o, result_valid_o, |result_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post-reset result", result_o, 32'd0);

    for (int i = 0; i < 7; i++) begin
      do_mul(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].prod);
      release_bus();
    end

    // Non-mul instruction must never engage the sequencer.
    begin
      int hits = 0;
      valid_i = 1'b1; ALUCtrl_i = ADD_CODE; src1_i = 32'd9; src2_i = 32'd9;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk_i);
        if (stall_o || busy_o || result_valid_o) hits++;
      end
      check("add passthrough", 32'(hits), 32'd0);
      valid_i = 1'b0;
    end

    // Flush at T+10: stall drops that cycle, IDLE next, no result, result kept.
    begin
      int vhits = 0;
      @(posedge clk_i); #1;
      valid_i = 1'b1; ALUCtrl_i = MUL_CODE; src1_i = 32'd3;
`ifdef ALU_MUL_SEQ_EARLY_TERM_EN
      src2_i = 32'h8000_0005;
`else
      src2_i = 32'd5;
`endif
      repeat (10) @(posedge clk_i);
      #1;
      flush_i = 1'b1; valid_i = 1'b0;
      @(negedge clk_i);
      check("flush stall", {31'd0, stall_o}, 32'd0);
      check("flush busy in T+10", {31'd0, busy_o}, 32'd1);
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      @(negedge clk_i);
      check("flush idle T+11", {31'd0, busy_o}, 32'd0);
      for (int k = 0; k < 40; k++) begin
        @(negedge clk_i);
        if (result_valid_o) vhits++;
      end
      check("flush no result_valid", 32'(vhits), 32'd0);
      check("flush result kept", result_o, vecs[6].prod);
    end

    // Reset mid-run, then a clean 2x2.
    @(posedge clk_i); #1;
    valid_i = 1'b1; ALUCtrl_i = MUL_CODE; src1_i = 32'd9; src2_i = 32'h8000_0009;
    repeat (5) @(posedge clk_i);
    #1;
    rst_i = 1'b1; valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("mid-run reset outputs", {28'd0, stall_o, busy_o, result_valid_o, |result_o}, 32'd0);
    do_mul("after reset 2x2", 32'd2, 32'd2, 32'd4);
    release_bus();

    // Back-to-back: second start accepted in the IDLE cycle after DONE.
    do_mul("b2b 4x4", 32'd4, 32'd4, 32'd16);
    do_mul("b2b 5x5", 32'd5, 32'd5, 32'd25);
    release_bus();
    repeat (3) @(posedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
